// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - opcode encodings (5-bit major opcode in insn[31:27])
//   - instruction field positions (rd[26:22], rs[21:17], rt[16:12])
//   - hazard sequencer FSM state encodings
//   - src_regs(): which register fields an instruction actually reads
// Ports: none (package).
// Configuration macro used by the top: HAZARD_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Major opcodes. An all-zero word is an ALU op on $r0 and acts as the NOP.
  localparam logic [4:0] OP_ALU = 5'd0;
  localparam logic [4:0] OP_LW  = 5'd1;
  localparam logic [4:0] OP_SW  = 5'd2;
  localparam logic [4:0] OP_BNE = 5'd3;
  localparam logic [4:0] OP_BLT = 5'd4;
  localparam logic [4:0] OP_JR  = 5'd5;

  // Instruction field slices.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RD_MSB = 26;
  localparam int RD_LSB = 22;
  localparam int RS_MSB = 21;
  localparam int RS_LSB = 17;
  localparam int RT_MSB = 16;
  localparam int RT_LSB = 12;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MD_DRAIN = 2'd2
  } hz_state_e;

  // Source register set of one instruction: up to two read ports.
  typedef struct packed {
    logic       rs_v;
    logic [4:0] rs;
    logic       rt_v;
    logic [4:0] rt;
  } src_regs_t;

  // Returns the registers an instruction reads. LW and JR read only rs
  // (base / target); stores and branches read both rs and rt.
  function automatic src_regs_t src_regs(input logic [31:0] insn);
    src_regs_t s;
    logic      unused_bits;
    unused_bits = ^{insn[RD_MSB:RD_LSB], insn[RT_LSB-1:0]};
    s.rs   = insn[RS_MSB:RS_LSB];
    s.rt   = insn[RT_MSB:RT_LSB];
    s.rs_v = 1'b0;
    s.rt_v = 1'b0;
    case (insn[OP_MSB:OP_LSB])
      OP_ALU, OP_SW, OP_BNE, OP_BLT: begin
        s.rs_v = 1'b1;
        s.rt_v = 1'b1;
      end
      OP_LW, OP_JR: begin
        s.rs_v = 1'b1;
        s.rt_v = 1'b0;
      end
      default: begin
        s.rs_v = 1'b0;
        s.rt_v = 1'b0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Combinational load-use comparator: flags when the load in D/X writes a
// register that the instruction in F/D reads. $r0 never produces a hazard.
// Ports:
//   i_fd_insn  in  32  instruction in F/D (consumer)
//   i_dx_insn  in  32  instruction in D/X (possible load)
//   o_lu_stall out 1   load-use hazard present
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_fd_insn,
  input  logic [31:0] i_dx_insn,
  output logic        o_lu_stall
);

  logic [4:0] w_dx_op;
  logic [4:0] w_dx_rd;
  src_regs_t  w_src;
  logic       w_unused_dx_bits;

  assign w_dx_op          = i_dx_insn[OP_MSB:OP_LSB];
  assign w_dx_rd          = i_dx_insn[RD_MSB:RD_LSB];
  assign w_src            = src_regs(i_fd_insn);
  assign w_unused_dx_bits = ^i_dx_insn[RS_MSB:0];

  // Load-use compare against each valid source of the consumer.
  always_comb begin
    o_lu_stall = 1'b0;
    if ((w_dx_op == OP_LW) && (w_dx_rd != 5'd0)) begin
      if ((w_src.rs_v && (w_src.rs == w_dx_rd)) ||
          (w_src.rt_v && (w_src.rt == w_dx_rd))) begin
        o_lu_stall = 1'b1;
      end else begin
        o_lu_stall = 1'b0;
      end
    end else begin
      o_lu_stall = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline (F, D, X, M, W). Produces the
// write-enable and NOP-insert controls of the PC and the F/D, D/X, X/M pipe
// registers, resolving load-use, multdiv occupancy and branch mispredict.
// Outputs are combinational from the registered FSM state and the inputs.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating counters
// o_stall_cycles (cycles with pc_we=0 outside reset) and o_flush_count
// (mispredict redirects).
//
// Parameters: MD_TIMEOUT (cycles allowed in MD_WAIT, >=2), CNT_W (counter width)
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_fd_insn, i_dx_insn     instructions in F/D and D/X (32b)
//   i_x_mispredict           X-stage branch resolved opposite to prediction
//   i_x_md_start             multdiv op entering execution (pulse)
//   i_md_ready               multdiv result valid (pulse)
//   o_pc_we, o_pc_redirect   PC write enable / select corrected target
//   o_fd_we, o_dx_we, o_xm_we            pipe-register write enables
//   o_fd_flush, o_dx_flush, o_xm_flush   load NOP at next edge
//   o_md_error               1-cycle pulse on multdiv timeout
//   o_stall_cycles, o_flush_count        (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fd_insn,
  input  logic [31:0] i_dx_insn,
  input  logic        i_x_mispredict,
  input  logic        i_x_md_start,
  input  logic        i_md_ready,
  output logic        o_pc_we,
  output logic        o_pc_redirect,
  output logic        o_fd_we,
  output logic        o_dx_we,
  output logic        o_xm_we,
  output logic        o_fd_flush,
  output logic        o_dx_flush,
  output logic        o_xm_flush,
  output logic        o_md_error
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
`endif
);

  localparam int                 MD_CNT_W    = $clog2(MD_TIMEOUT);
  localparam logic [MD_CNT_W-1:0] LP_CNT_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
  localparam logic [MD_CNT_W-1:0] LP_CNT_ONE  = MD_CNT_W'(1);

  hz_state_e           r_state;
  hz_state_e           w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;

  logic w_lu_stall;
  logic w_mispredict_evt;
  logic w_pc_we;
  logic w_pc_redirect;
  logic w_fd_we;
  logic w_dx_we;
  logic w_xm_we;
  logic w_fd_flush;
  logic w_dx_flush;
  logic w_xm_flush;
  logic w_md_error;

  pipe_hazard_ctrl_hazard_detect u_hazard_detect (
    .i_fd_insn  (i_fd_insn),
    .i_dx_insn  (i_dx_insn),
    .o_lu_stall (w_lu_stall)
  );

  // FSM state and multdiv timeout counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_RUN;
      r_md_cnt <= {MD_CNT_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Next-state and raw pipeline controls.
  always_comb begin
    w_state_nxt      = r_state;
    w_md_cnt_nxt     = {MD_CNT_W{1'b0}};
    w_pc_we          = 1'b1;
    w_pc_redirect    = 1'b0;
    w_fd_we          = 1'b1;
    w_dx_we          = 1'b1;
    w_xm_we          = 1'b1;
    w_fd_flush       = 1'b0;
    w_dx_flush       = 1'b0;
    w_xm_flush       = 1'b0;
    w_md_error       = 1'b0;
    w_mispredict_evt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_x_mispredict) begin
          // Redirect wins; the wrong-path F/D and D/X contents are squashed,
          // so any load-use pairing among them is irrelevant.
          w_pc_redirect    = 1'b1;
          w_fd_flush       = 1'b1;
          w_dx_flush       = 1'b1;
          w_mispredict_evt = 1'b1;
        end else if (i_x_md_start) begin
          w_state_nxt = ST_MD_WAIT;
        end else if (w_lu_stall) begin
          // Hold PC and F/D, bubble into D/X for exactly one cycle.
          w_pc_we    = 1'b0;
          w_fd_we    = 1'b0;
          w_dx_flush = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MD_WAIT: begin
        // X is occupied by the multdiv op: freeze front end, bubble into M.
        w_pc_we    = 1'b0;
        w_fd_we    = 1'b0;
        w_dx_we    = 1'b0;
        w_xm_flush = 1'b1;
        if (i_md_ready) begin
          w_state_nxt = ST_MD_DRAIN;
        end else if (r_md_cnt == LP_CNT_LAST) begin
          w_md_error  = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_md_cnt_nxt = r_md_cnt + LP_CNT_ONE;
        end
      end
      ST_MD_DRAIN: begin
        // Result moves into X/M; the front end resumes with the usual check.
        w_state_nxt = ST_RUN;
        if (w_lu_stall) begin
          w_pc_we    = 1'b0;
          w_fd_we    = 1'b0;
          w_dx_flush = 1'b1;
        end else begin
          w_pc_we = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Output stage: everything quiet while reset is asserted.
  always_comb begin
    o_pc_we       = 1'b0;
    o_pc_redirect = 1'b0;
    o_fd_we       = 1'b0;
    o_dx_we       = 1'b0;
    o_xm_we       = 1'b0;
    o_fd_flush    = 1'b0;
    o_dx_flush    = 1'b0;
    o_xm_flush    = 1'b0;
    o_md_error    = 1'b0;
    if (i_reset) begin
      o_pc_we = 1'b0;
    end else begin
      o_pc_we       = w_pc_we;
      o_pc_redirect = w_pc_redirect;
      o_fd_we       = w_fd_we;
      o_dx_we       = w_dx_we;
      o_xm_we       = w_xm_we;
      o_fd_flush    = w_fd_flush;
      o_dx_flush    = w_dx_flush;
      o_xm_flush    = w_xm_flush;
      o_md_error    = w_md_error;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_flush_count  <= {CNT_W{1'b0}};
    end else begin
      if (!w_pc_we && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_mispredict_evt && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_mispredict_evt & (CNT_W > 0);
`endif

endmodule
